// File: rtl/alarm_tone_pkg.sv
// Mode encodings and FSM state enum shared by the alarm tone generator.
package alarm_tone_pkg;

    typedef enum logic [1:0] {
        MODE_CONT  = 2'd0,
        MODE_BEEP  = 2'd1,
        MODE_BURST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

endpackage

// File: rtl/alarm_tone_gen_tone_divider.sv
// Square-wave divider: toggles tone every half CLK cycles while enabled; clr forces count and tone to 0.
// Latency: tone changes on the edge after the half-th enabled cycle; no backpressure.
module tone_divider
    import alarm_tone_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] half,
    output logic             tone
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (clr) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (en) begin
            // >= keeps the counter bounded even if half shrinks mid-count
            if (cnt_q >= half - DIV_W'(1)) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm pattern generator (CONT / BEEP / BURST) driving a piezo square wave; ALARM_TWO_TONE_EN doubles even ON-phase periods.
// Latency: busy and tone start one cycle after start; stop takes effect next cycle. No backpressure.
module alarm_tone_gen
    import alarm_tone_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int TICK_W = 16,
    parameter int REP_W  = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              tick_en,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  half_period,
    input  logic [TICK_W-1:0] on_ticks,
    input  logic [TICK_W-1:0] off_ticks,
    input  logic [REP_W-1:0]  repeats,
    output logic              buzzer,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DIV_W-1:0]  hp_q, hp_d;
    logic [TICK_W-1:0] on_q, on_d, off_q, off_d, ph_q, ph_d;
    logic [REP_W-1:0]  rep_q, rep_d, on_num_q, on_num_d;
    logic              done_q, done_d;

    logic [DIV_W-1:0]  hp_eff, half_sel;
    logic [TICK_W-1:0] on_eff, off_eff, ph_inc;
    logic [REP_W-1:0]  rep_eff;

    // Zero-valued settings behave as 1 so every phase has finite, non-zero length.
    assign hp_eff  = (hp_q  == '0) ? DIV_W'(1)  : hp_q;
    assign on_eff  = (on_q  == '0) ? TICK_W'(1) : on_q;
    assign off_eff = (off_q == '0) ? TICK_W'(1) : off_q;
    assign rep_eff = (rep_q == '0) ? REP_W'(1)  : rep_q;
    assign ph_inc  = ph_q + TICK_W'(1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hp_d     = hp_q;
        on_d     = on_q;
        off_d    = off_q;
        rep_d    = rep_q;
        ph_d     = ph_q;
        on_num_d = on_num_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop && mode != MODE_RSVD) begin
                    mode_d   = mode_e'(mode);
                    hp_d     = half_period;
                    on_d     = on_ticks;
                    off_d    = off_ticks;
                    rep_d    = repeats;
                    ph_d     = '0;
                    on_num_d = REP_W'(1);
                    state_d  = ST_ON;
                end
            end
            ST_ON: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    ph_d    = '0;
                end else if (mode_q != MODE_CONT && tick_en) begin
                    if (ph_inc == on_eff) begin
                        ph_d = '0;
                        if (mode_q == MODE_BURST && on_num_q >= rep_eff) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end else begin
                        ph_d = ph_inc;
                    end
                end
            end
            ST_OFF: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    ph_d    = '0;
                end else if (tick_en) begin
                    if (ph_inc == off_eff) begin
                        ph_d    = '0;
                        state_d = ST_ON;
                        if (on_num_q != '1) begin
                            on_num_d = on_num_q + REP_W'(1);
                        end
                    end else begin
                        ph_d = ph_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_CONT;
            hp_q     <= '0;
            on_q     <= '0;
            off_q    <= '0;
            rep_q    <= '0;
            ph_q     <= '0;
            on_num_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            hp_q     <= hp_d;
            on_q     <= on_d;
            off_q    <= off_d;
            rep_q    <= rep_d;
            ph_q     <= ph_d;
            on_num_q <= on_num_d;
            done_q   <= done_d;
        end
    end

`ifdef ALARM_TWO_TONE_EN
    logic           even_q, even_d;
    logic [DIV_W:0] hp_dbl;

    always_comb begin
        even_d = even_q;
        if (state_q == ST_IDLE && state_d == ST_ON) begin
            even_d = 1'b0;
        end else if (state_q == ST_OFF && state_d == ST_ON) begin
            even_d = ~even_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            even_q <= 1'b0;
        end else begin
            even_q <= even_d;
        end
    end

    assign hp_dbl   = {1'b0, hp_eff} << 1;
    assign half_sel = (even_q && mode_q != MODE_CONT)
                    ? (hp_dbl[DIV_W] ? '1 : hp_dbl[DIV_W-1:0]) : hp_eff;
`else
    assign half_sel = hp_eff;
`endif

    // Clearing on the edge that leaves ON drops the tone together with the state change.
    tone_divider #(.DIV_W(DIV_W)) u_div (
        .CLK  (CLK),
        .RSTN (RSTN),
        .clr  ((state_q != ST_ON) || (state_d != ST_ON)),
        .en   (state_d == ST_ON),
        .half (half_sel),
        .tone (buzzer)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Bench for alarm_tone_gen: directed vector table, hand sequences and random stimulus against a behavioural model.
module tb_alarm_tone_gen;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        tick_en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] half_period = '0;
    logic [15:0] on_ticks = '0;
    logic [15:0] off_ticks = '0;
    logic [7:0]  repeats = '0;
    logic        buzzer, busy, done;

    int checks = 0;
    int errors = 0;

    alarm_tone_gen dut (
        .CLK(CLK), .RSTN(RSTN), .tick_en(tick_en), .start(start), .stop(stop),
        .mode(mode), .half_period(half_period), .on_ticks(on_ticks),
        .off_ticks(off_ticks), .repeats(repeats),
        .buzzer(buzzer), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: pattern position tracked as phase/tick counts, tone derived arithmetically.
    bit m_busy, m_on, m_done;
    int m_mode, m_hp, m_on_len, m_off_len, m_rep, m_cyc, m_ticks, m_idx;

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic bit exp_buz();
        int hpc;
        if (!(m_busy && m_on)) return 1'b0;
        hpc = m_hp;
`ifdef ALARM_TWO_TONE_EN
        if (m_mode != 0 && (m_idx % 2) == 0) hpc = (2 * m_hp > 65535) ? 65535 : 2 * m_hp;
`endif
        return ((m_cyc / hpc) % 2) == 1;
    endfunction

    task automatic model_edge(input bit r, st, sp, tk, input int md, hp, onl, offl, rp);
        m_done = 1'b0;
        if (!r) begin
            m_busy = 0; m_on = 0; m_cyc = 0; m_ticks = 0; m_idx = 0;
        end else if (!m_busy) begin
            if (st && !sp && md != 3) begin
                m_mode = md; m_hp = max1(hp); m_on_len = max1(onl);
                m_off_len = max1(offl); m_rep = max1(rp);
                m_busy = 1; m_on = 1; m_cyc = 0; m_ticks = 0; m_idx = 1;
            end
        end else if (sp) begin
            m_busy = 0; m_on = 0;
        end else if (m_on) begin
            m_cyc++;
            if (m_mode != 0 && tk) begin
                m_ticks++;
                if (m_ticks == m_on_len) begin
                    m_ticks = 0; m_on = 0;
                    if (m_mode == 2 && m_idx == m_rep) begin
                        m_busy = 0; m_done = 1;
                    end
                end
            end
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == m_off_len) begin
                m_ticks = 0; m_on = 1; m_cyc = 0; m_idx++;
            end
        end
    endtask

    task automatic step(input bit r, st, sp, tk, input logic [1:0] md,
                        input logic [15:0] hp, onl, offl, input logic [7:0] rp);
        @(negedge CLK);
        RSTN = r; start = st; stop = sp; tick_en = tk; mode = md;
        half_period = hp; on_ticks = onl; off_ticks = offl; repeats = rp;
        @(posedge CLK);
        model_edge(r, st, sp, tk, int'(md), int'(hp), int'(onl), int'(offl), int'(rp));
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit r, st, sp, tk;
        logic [1:0] md;
        logic [15:0] hp, onl, offl;
        logic [7:0] rp;
        bit e_busy, e_buz, e_done;
    } vec_t;

    function automatic vec_t mk(input bit r, st, sp, tk, input logic [1:0] md,
                                input logic [15:0] hp, onl, offl, input logic [7:0] rp,
                                input bit eb, ez, ed);
        vec_t v;
        v.r = r; v.st = st; v.sp = sp; v.tk = tk; v.md = md; v.hp = hp;
        v.onl = onl; v.offl = offl; v.rp = rp; v.e_busy = eb; v.e_buz = ez; v.e_done = ed;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        bit two_tone = 1'b0;
        int rises, busy_cnt, done_cnt, done_at_fall, first_rise, second_rise;
        bit prev_buz, prev_busy;
`ifdef ALARM_TWO_TONE_EN
        two_tone = 1'b1;
`endif
        //           r  st sp tk md  hp  on off rp   busy buz done
        tbl[0]  = mk(0, 0, 0, 0, 0,  0,  0, 0,  0,   0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 0,  4,  1, 1,  1,   0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 3,  4,  1, 1,  1,   0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0,  2,  1, 1,  1,   1, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0,  0,  0, 0,  0,   1, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0,  0,  0, 0,  0,   1, 1, 0);
        tbl[6]  = mk(1, 1, 0, 0, 1,  7,  0, 0,  0,   1, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0,  0,  0, 0,  0,   1, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0, 0,  0,  0, 0,  0,   0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 2,  0,  0, 0,  0,   1, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 0,  0,  0, 0,  0,   1, 1, 0);
        tbl[11] = mk(1, 0, 0, 1, 0,  0,  0, 0,  0,   0, 0, 1);
        tbl[12] = mk(1, 0, 0, 0, 0,  0,  0, 0,  0,   0, 0, 0);
        tbl[13] = mk(1, 1, 0, 0, 1,  1,  1, 1,  0,   1, 0, 0);
        tbl[14] = mk(1, 0, 0, 1, 0,  0,  0, 0,  0,   1, 0, 0);
        tbl[15] = mk(1, 0, 0, 1, 0,  0,  0, 0,  0,   1, 0, 0);
        tbl[16] = mk(1, 0, 0, 0, 0,  0,  0, 0,  0,   1, !two_tone, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,  0,  0, 0,  0,   0, 0, 0);
        tbl[18] = mk(1, 1, 0, 0, 0,  1,  0, 0,  0,   1, 0, 0);
        tbl[19] = mk(1, 0, 0, 0, 0,  0,  0, 0,  0,   1, 1, 0);
        tbl[20] = mk(1, 0, 1, 0, 0,  0,  0, 0,  0,   0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].st, tbl[i].sp, tbl[i].tk, tbl[i].md,
                 tbl[i].hp, tbl[i].onl, tbl[i].offl, tbl[i].rp);
            check($sformatf("vec%0d_outs", i), {29'd0, busy, buzzer, done},
                  {29'd0, tbl[i].e_busy, tbl[i].e_buz, tbl[i].e_done});
        end

        // CONT, half-period 4: first rise 4 cycles after entry, period 8, then stop.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 4, 0, 0, 0);
        first_rise = -1; second_rise = -1; prev_buz = buzzer;
        for (int c = 1; c <= 20; c++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0);
            if (buzzer && !prev_buz) begin
                if (first_rise < 0) first_rise = c;
                else if (second_rise < 0) second_rise = c;
            end
            prev_buz = buzzer;
        end
        check("cont_first_rise", first_rise, 4);
        check("cont_second_rise", second_rise, 12);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        check("cont_stop", {30'd0, busy, buzzer}, 32'd0);

        // BURST on=2 off=1 repeats=3, tick every 10 cycles aligned with start.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rises = 0; busy_cnt = 0; done_cnt = 0; done_at_fall = 0;
        prev_buz = 1'b0; prev_busy = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(1, c == 0, 0, (c % 10) == 0, 2, 5, 2, 1, 3);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (!busy && prev_busy) done_at_fall++;
            end
            if (buzzer && !prev_buz) rises++;
            prev_buz = buzzer; prev_busy = busy;
        end
        check("burst_busy_cycles", busy_cnt, 80);
        check("burst_done_pulses", done_cnt, 1);
        check("burst_done_at_busy_fall", done_at_fall, 1);
        check("burst_tone_rises", rises, two_tone ? 5 : 6);

        // Random stimulus against the model.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 4)),
                 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                 8'($urandom_range(0, 4)));
            check($sformatf("rand%0d_busy_buz_done", c), {29'd0, busy, buzzer, done},
                  {29'd0, m_busy, exp_buz(), m_done});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_tone_gen.md
ALARM_TONE_GEN -- requirements
Module: alarm_tone_gen

Interface
REQ-001 Parameter DIV_W, default 16, width of tone half-period divider.
REQ-002 Parameter TICK_W, default 16, width of on/off phase durations counted in time-base ticks.
REQ-003 Parameter REP_W, default 8, width of burst repeat count.
REQ-004 CLK  input  1  single clock, all logic on rising edge.
REQ-005 RSTN  input  1  reset, synchronous, active-low.
REQ-006 tick_en  input  1  one-cycle time-base strobe, e.g. 1 kHz, for phase timing.
REQ-007 start  input  1  one-cycle request to begin a pattern.
REQ-008 stop  input  1  one-cycle request to abort the pattern.
REQ-009 mode  input  2  0=CONT, 1=BEEP, 2=BURST, 3=reserved.
REQ-010 half_period  input  DIV_W  tone half-period in CLK cycles.
REQ-011 on_ticks  input  TICK_W  ON phase length in tick_en strobes.
REQ-012 off_ticks  input  TICK_W  OFF phase length in tick_en strobes.
REQ-013 repeats  input  REP_W  number of ON phases in BURST.
REQ-014 buzzer  output  1  square-wave drive to piezo.
REQ-015 busy  output  1  high while a pattern is active.
REQ-016 done  output  1  one-cycle pulse at normal BURST completion.

Function
REQ-017 FSM states IDLE, ON, OFF; busy SHALL equal (state != IDLE).
REQ-018 In IDLE, start with mode 0..2 and stop low SHALL latch mode, half_period, on_ticks, off_ticks, repeats and enter ON next cycle; mode 3 SHALL be ignored.
REQ-019 start while busy SHALL be ignored; latched configuration SHALL not change mid-pattern.
REQ-020 Latched half_period 0 SHALL be treated as 1; on_ticks, off_ticks, repeats of 0 SHALL each be treated as 1.
REQ-021 On entering ON, tone counter SHALL clear and buzzer SHALL be 0; buzzer SHALL toggle every half_period CLK cycles while in ON (period 2*half_period).
REQ-022 In OFF and IDLE, buzzer SHALL be 0 and tone counter held at 0.
REQ-023 Phase counter SHALL clear on each phase entry and increment only on tick_en; phase ends on the tick_en making count equal its length, transition effective next cycle.
REQ-024 CONT: remain in ON until stop.
REQ-025 BEEP: alternate ON/OFF indefinitely until stop.
REQ-026 BURST: after the repeats-th ON phase, go directly to IDLE (no trailing OFF) and assert done for that one cycle; ON count SHALL not wrap.
REQ-027 stop in any busy state SHALL force IDLE next cycle, buzzer 0, no done pulse.
REQ-028 start and stop asserted together in IDLE: stop wins, stay IDLE.

Reset
REQ-029 RSTN low at a rising CLK edge SHALL set state IDLE, buzzer 0, busy 0, done 0, all counters and latched config 0, including mid-pattern.

Configuration
REQ-030 With ALARM_TWO_TONE_EN defined, in BEEP and BURST every even-numbered ON phase (2nd, 4th, ...) SHALL use half-period 2*half_period (saturating at DIV_W all-ones); CONT unaffected.
REQ-031 Without ALARM_TWO_TONE_EN, all ON phases SHALL use latched half_period; no extra logic present.

Structure
REQ-032 Package alarm_tone_pkg SHALL hold mode encodings and FSM state enum.
REQ-033 Sub-module tone_divider SHALL implement the clear/enable/half-period toggle counter; FSM and phase counting stay in alarm_tone_gen.

Verification
REQ-034 CONT, half_period=4, start -> busy at +1 cycle, buzzer first rises 4 cycles later, period 8; stop -> buzzer 0 and busy 0 next cycle.
REQ-035 BURST, on=2, off=1, repeats=3, tick_en every 10 cycles -> exactly 3 ON windows of 20 cycles, 2 OFF windows of 10, one done pulse, busy falls same cycle.
REQ-036 start and stop same cycle in IDLE -> busy stays 0; start during BEEP -> no config change.
REQ-037 RSTN low mid-BEEP ON -> next edge buzzer 0, busy 0, done 0; release then start -> normal pattern.
REQ-038 half_period=0, on_ticks=0 -> buzzer toggles every cycle, ON lasts one tick.
REQ-039 ALARM_TWO_TONE_EN, BEEP half_period=3 -> ON phases alternate period 6 and 12; without macro all period 6.
